// File: rtl/snow64_instr_fetch_stage_pkg.sv
// Shared types for the Snow64 instruction fetch stage: address/instruction
// words and the {instr, pc} entry held by the fetch FIFOs.
package PkgSnow64InstrFetch;

    localparam int unsigned WIDTH__ADDR       = 64;
    localparam int unsigned WIDTH__INSTR      = 32;
    localparam int unsigned WIDTH__FETCH_INCR = 4;

    typedef logic [WIDTH__ADDR-1:0]  FetchAddr;
    typedef logic [WIDTH__INSTR-1:0] FetchInstr;

    typedef struct packed {
        FetchInstr instr;
        FetchAddr  pc;
    } FetchBufEntry;

endpackage

// File: rtl/snow64_instr_fetch_stage_fifo.sv
// Small synchronous FIFO of FetchBufEntry with flush; head is read combinationally.
// Callers must not push when full or pop when empty.
module snow64_fetch_fifo
    import PkgSnow64InstrFetch::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  FetchBufEntry                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output FetchBufEntry                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    FetchBufEntry     mem_q [DEPTH];
    FetchBufEntry     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/snow64_instr_fetch_stage.sv
// Snow64 fetch stage: owns the fetch PC, issues one read per request, buffers
// returned instructions in order with their PC, and handles execute redirects.
module snow64_instr_fetch_stage #(
    parameter int unsigned             WIDTH__ADDR  = PkgSnow64InstrFetch::WIDTH__ADDR,
    parameter int unsigned             WIDTH__INSTR = PkgSnow64InstrFetch::WIDTH__INSTR,
    parameter int unsigned             DEPTH__BUF   = 2,
    parameter logic [WIDTH__ADDR-1:0]  RESET_PC     = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     out_req_valid,
    output logic [WIDTH__ADDR-1:0]   out_req_addr,
    input  logic                     in_req_ready,
    input  logic                     in_resp_valid,
    input  logic [WIDTH__INSTR-1:0]  in_resp_instr,
    input  logic                     in_redirect_valid,
    input  logic [WIDTH__ADDR-1:0]   in_redirect_pc,
    input  logic                     in_decoder_stall,
    output logic                     out_instr_valid,
    output logic [WIDTH__INSTR-1:0]  out_instr,
    output logic [WIDTH__ADDR-1:0]   out_instr_pc
);

    localparam int unsigned CNT_W  = $clog2(DEPTH__BUF + 1);
    // Headroom so discards can pile up across several redirects against a slow memory.
    localparam int unsigned DROP_W = CNT_W + 4;

    PkgSnow64InstrFetch::FetchBufEntry buf_push_data, buf_head;
    PkgSnow64InstrFetch::FetchBufEntry pend_push_data, pend_head;

    logic [CNT_W-1:0]        buf_count, pend_count;
    logic [CNT_W:0]          in_use;
    logic [WIDTH__ADDR-1:0]  pc_q, pc_d;
    logic [DROP_W-1:0]       drop_q, drop_d, drop_plus;
    logic                    req_fire, resp_take, buf_pop;
    logic                    unused_pend_instr;

    always_comb begin
        in_use        = {1'b0, buf_count} + {1'b0, pend_count};
        out_req_valid = !rst && !in_redirect_valid && (in_use < (CNT_W+1)'(DEPTH__BUF));
        req_fire      = out_req_valid && in_req_ready;
        resp_take     = in_resp_valid && !in_redirect_valid && (drop_q == '0) && (pend_count != '0);
        buf_pop       = (buf_count != '0) && !in_decoder_stall && !in_redirect_valid;

        pend_push_data       = '0;
        pend_push_data.pc    = pc_q;
        buf_push_data.instr  = in_resp_instr;
        buf_push_data.pc     = pend_head.pc;

        pc_d      = pc_q;
        drop_d    = drop_q;
        drop_plus = drop_q + DROP_W'(pend_count);
        if (in_redirect_valid) begin
            pc_d = in_redirect_pc;
            // Everything in flight becomes a discard; a response landing now is one of them.
            drop_d = (in_resp_valid && (drop_plus != '0)) ? drop_plus - 1'b1 : drop_plus;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + WIDTH__ADDR'(PkgSnow64InstrFetch::WIDTH__FETCH_INCR);
            end
            if (in_resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    snow64_fetch_fifo #(
        .DEPTH (DEPTH__BUF)
    ) u_pend_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pend_push_data),
        .pop       (resp_take),
        .flush     (in_redirect_valid),
        .head      (pend_head),
        .count     (pend_count)
    );

    snow64_fetch_fifo #(
        .DEPTH (DEPTH__BUF)
    ) u_instr_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_take),
        .push_data (buf_push_data),
        .pop       (buf_pop),
        .flush     (in_redirect_valid),
        .head      (buf_head),
        .count     (buf_count)
    );

    assign unused_pend_instr = ^pend_head.instr;

    assign out_req_addr    = pc_q;
    assign out_instr_valid = (buf_count != '0);
    assign out_instr       = buf_head.instr;
    assign out_instr_pc    = buf_head.pc;

endmodule

// File: tb/tb_snow64_instr_fetch_stage.sv
// Bench for snow64_instr_fetch_stage: an in-order latency memory plus a
// queue-based model of fetch PC, pending requests, discards and the buffer.
module tb_snow64_instr_fetch_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        int unsigned due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_req_valid;
    logic [63:0] out_req_addr;
    logic        ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_instr = '0;
    logic        redir = 1'b0;
    logic [63:0] redir_pc = '0;
    logic        stall = 1'b0;
    logic        out_instr_valid;
    logic [31:0] out_instr;
    logic [63:0] out_instr_pc;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [63:0] m_pc = '0;
    int          m_drop = 0;
    ent_t        m_buf[$];
    logic [63:0] m_pend[$];
    mreq_t       memq[$];
    int unsigned cyc = 0;
    int unsigned lat = 1;

    snow64_instr_fetch_stage #(
        .WIDTH__ADDR  (64),
        .WIDTH__INSTR (32),
        .DEPTH__BUF   (2),
        .RESET_PC     (64'h0)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .out_req_valid     (out_req_valid),
        .out_req_addr      (out_req_addr),
        .in_req_ready      (ready),
        .in_resp_valid     (resp_valid),
        .in_resp_instr     (resp_instr),
        .in_redirect_valid (redir),
        .in_redirect_pc    (redir_pc),
        .in_decoder_stall  (stall),
        .out_instr_valid   (out_instr_valid),
        .out_instr         (out_instr),
        .out_instr_pc      (out_instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic exp_req_valid();
        return !rst && !redir && (m_buf.size() + m_pend.size() < 2);
    endfunction

    task automatic model_clear();
        m_pc   = '0;
        m_drop = 0;
        m_buf.delete();
        m_pend.delete();
    endtask

    // Present this cycle's memory response, then wait to the sampling edge.
    task automatic settle();
        resp_valid = (memq.size() > 0) && (memq[0].due <= cyc);
        resp_instr = resp_valid ? memq[0].instr : $urandom;
        @(negedge clk);
    endtask

    task automatic commit();
        logic fire;
        ent_t e;
        @(posedge clk);
        fire = exp_req_valid() && ready;
        if (resp_valid) void'(memq.pop_front());
        if (fire) memq.push_back('{instr: $urandom, due: cyc + lat});
        if (!rst) begin
            if (redir) begin
                if (resp_valid && (m_drop + m_pend.size() > 0)) m_drop = m_drop + m_pend.size() - 1;
                else m_drop = m_drop + m_pend.size();
                m_pend.delete();
                m_buf.delete();
                m_pc = redir_pc;
            end else begin
                if (m_buf.size() > 0 && !stall) void'(m_buf.pop_front());
                if (resp_valid) begin
                    if (m_drop > 0) m_drop--;
                    else if (m_pend.size() > 0) begin
                        e.instr = resp_instr;
                        e.pc    = m_pend.pop_front();
                        m_buf.push_back(e);
                    end
                end
                if (fire) begin
                    m_pend.push_back(m_pc);
                    m_pc = m_pc + 64'd4;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ready = 1'b0;
        model_clear();
        repeat (3) commit();
        settle();
        vectors += 4;
        if (out_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid got=%b want=0", out_req_valid); end
        if (out_instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_instr_valid got=%b want=0", out_instr_valid); end
        if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got=%h want=0", out_instr); end
        if (out_instr_pc !== 64'h0) begin miscompares++; $display("FAIL reset_instr_pc got=%h want=0", out_instr_pc); end
        commit();
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        ready = 1'b1; stall = 1'b0; lat = 1;
        for (int i = 0; i < 14; i++) begin
            settle();
            vectors += 3;
            if (out_req_valid !== exp_req_valid()) begin miscompares++; $display("FAIL run_req_valid cyc=%0d got=%b want=%b", cyc, out_req_valid, exp_req_valid()); end
            if (out_req_addr !== m_pc) begin miscompares++; $display("FAIL run_req_addr cyc=%0d got=%h want=%h", cyc, out_req_addr, m_pc); end
            if (out_instr_valid !== (m_buf.size() != 0)) begin miscompares++; $display("FAIL run_instr_valid cyc=%0d got=%b want=%b", cyc, out_instr_valid, m_buf.size() != 0); end
            if (m_buf.size() != 0) begin
                vectors += 2;
                if (out_instr_pc !== m_buf[0].pc) begin miscompares++; $display("FAIL run_instr_pc cyc=%0d got=%h want=%h", cyc, out_instr_pc, m_buf[0].pc); end
                if (out_instr !== m_buf[0].instr) begin miscompares++; $display("FAIL run_instr cyc=%0d got=%h want=%h", cyc, out_instr, m_buf[0].instr); end
            end
            commit();
        end
    endtask

    task automatic test_stall();
        logic [63:0] held_pc;
        logic [31:0] held_instr;
        stall = 1'b1;
        settle();
        held_pc    = (m_buf.size() != 0) ? m_buf[0].pc : '0;
        held_instr = (m_buf.size() != 0) ? m_buf[0].instr : '0;
        commit();
        for (int i = 0; i < 6; i++) begin
            settle();
            if (i >= 2) begin
                vectors += 4;
                if (out_req_valid !== 1'b0) begin miscompares++; $display("FAIL stall_req_valid got=%b want=0", out_req_valid); end
                if (out_instr_valid !== 1'b1) begin miscompares++; $display("FAIL stall_instr_valid got=%b want=1", out_instr_valid); end
                if (out_instr_pc !== held_pc) begin miscompares++; $display("FAIL stall_hold_pc got=%h want=%h", out_instr_pc, held_pc); end
                if (out_instr !== held_instr) begin miscompares++; $display("FAIL stall_hold_instr got=%h want=%h", out_instr, held_instr); end
            end
            commit();
        end
        stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            vectors++;
            if (out_instr_valid !== (m_buf.size() != 0)) begin miscompares++; $display("FAIL release_valid got=%b want=%b", out_instr_valid, m_buf.size() != 0); end
            if (m_buf.size() != 0) begin
                vectors++;
                if (out_instr_pc !== held_pc) begin miscompares++; $display("FAIL release_order got=%h want=%h", out_instr_pc, held_pc); end
                held_pc = held_pc + 64'd4;
            end
            commit();
        end
    endtask

    task automatic test_redirect_outstanding();
        logic found = 1'b0;
        ready = 1'b1; stall = 1'b0; lat = 3;
        for (int i = 0; i < 20 && !found; i++) begin
            settle();
            if (m_pend.size() == 2) found = 1'b1;
            else commit();
        end
        if (!found) begin
            vectors++; miscompares++;
            $display("FAIL redir2_setup got=no_two_outstanding want=two_outstanding");
            return;
        end
        redir = 1'b1; redir_pc = 64'h1000;
        #1;
        vectors++;
        if (out_req_valid !== 1'b0) begin miscompares++; $display("FAIL redir2_req_valid got=%b want=0", out_req_valid); end
        commit();
        redir = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            settle();
            if (out_instr_valid === 1'b1 || m_buf.size() != 0) begin
                found = 1'b1;
                vectors += 2;
                if (out_instr_valid !== 1'b1) begin miscompares++; $display("FAIL redir2_valid got=%b want=1", out_instr_valid); end
                if (out_instr_pc !== 64'h1000) begin miscompares++; $display("FAIL redir2_first_pc got=%h want=1000", out_instr_pc); end
            end
            commit();
        end
        if (!found) begin vectors++; miscompares++; $display("FAIL redir2_timeout got=no_instr want=pc_1000"); end
    endtask

    task automatic test_redirect_coincident();
        logic found = 1'b0;
        ready = 1'b1; stall = 1'b0; lat = 1;
        for (int i = 0; i < 20 && !found; i++) begin
            settle();
            if (resp_valid && m_buf.size() != 0) found = 1'b1;
            else commit();
        end
        if (!found) begin
            vectors++; miscompares++;
            $display("FAIL coinc_setup got=no_resp_with_head want=resp_with_head");
            return;
        end
        redir = 1'b1; redir_pc = 64'h2000;
        #1;
        vectors++;
        if (out_req_valid !== 1'b0) begin miscompares++; $display("FAIL coinc_req_valid got=%b want=0", out_req_valid); end
        commit();
        redir = 1'b0;
        settle();
        vectors += 2;
        if (out_instr_valid !== 1'b0) begin miscompares++; $display("FAIL coinc_flushed got=%b want=0", out_instr_valid); end
        if (out_req_addr !== 64'h2000) begin miscompares++; $display("FAIL coinc_new_pc got=%h want=2000", out_req_addr); end
        commit();
    endtask

    task automatic test_pc_wrap();
        ready = 1'b1; stall = 1'b0; lat = 1;
        redir = 1'b1; redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        settle();
        commit();
        redir = 1'b0;
        settle();
        vectors += 2;
        if (out_req_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_req_valid got=%b want=1", out_req_valid); end
        if (out_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr0 got=%h want=fffffffffffffffc", out_req_addr); end
        commit();
        settle();
        vectors++;
        if (out_req_addr !== 64'h0) begin miscompares++; $display("FAIL wrap_addr1 got=%h want=0", out_req_addr); end
        commit();
        repeat (4) begin settle(); commit(); end
    endtask

    task automatic test_async_reset();
        ready = 1'b1; stall = 1'b1; lat = 1;
        repeat (6) begin settle(); commit(); end
        stall = 1'b0; lat = 4;
        settle(); commit();
        stall = 1'b1;
        repeat (2) begin settle(); commit(); end
        settle();
        #2 rst = 1'b1;
        model_clear();
        #1;
        vectors += 3;
        if (out_instr_valid !== 1'b0) begin miscompares++; $display("FAIL areset_instr_valid got=%b want=0", out_instr_valid); end
        if (out_req_valid !== 1'b0) begin miscompares++; $display("FAIL areset_req_valid got=%b want=0", out_req_valid); end
        if (out_instr_pc !== 64'h0) begin miscompares++; $display("FAIL areset_instr_pc got=%h want=0", out_instr_pc); end
        commit();
        ready = 1'b0; stall = 1'b0;
        settle(); commit();
        rst = 1'b0;
        for (int i = 0; i < 20 && memq.size() != 0; i++) begin
            settle();
            vectors++;
            if (out_instr_valid !== 1'b0) begin miscompares++; $display("FAIL stale_resp_output got=%b want=0", out_instr_valid); end
            commit();
        end
        if (memq.size() != 0) begin vectors++; miscompares++; $display("FAIL stale_drain got=%0d want=0", memq.size()); end
        settle();
        vectors++;
        if (out_instr_valid !== 1'b0) begin miscompares++; $display("FAIL stale_final got=%b want=0", out_instr_valid); end
        commit();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            ready    = ($urandom % 4) != 0;
            stall    = ($urandom % 3) == 0;
            redir    = ($urandom % 12) == 0;
            redir_pc = {$urandom, $urandom};
            lat      = $urandom_range(1, 4);
            settle();
            vectors += 3;
            if (out_req_valid !== exp_req_valid()) begin miscompares++; $display("FAIL rnd_req_valid cyc=%0d got=%b want=%b", cyc, out_req_valid, exp_req_valid()); end
            if (out_req_addr !== m_pc) begin miscompares++; $display("FAIL rnd_req_addr cyc=%0d got=%h want=%h", cyc, out_req_addr, m_pc); end
            if (out_instr_valid !== (m_buf.size() != 0)) begin miscompares++; $display("FAIL rnd_instr_valid cyc=%0d got=%b want=%b", cyc, out_instr_valid, m_buf.size() != 0); end
            if (m_buf.size() != 0) begin
                vectors += 2;
                if (out_instr_pc !== m_buf[0].pc) begin miscompares++; $display("FAIL rnd_instr_pc cyc=%0d got=%h want=%h", cyc, out_instr_pc, m_buf[0].pc); end
                if (out_instr !== m_buf[0].instr) begin miscompares++; $display("FAIL rnd_instr cyc=%0d got=%h want=%h", cyc, out_instr, m_buf[0].instr); end
            end
            commit();
        end
        redir = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_outstanding();
        test_redirect_coincident();
        test_pc_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snow64_instr_fetch_stage.md
Name: snow64_instr_fetch_stage

Overview:
Instruction fetch stage directly upstream of the Snow64 instruction decoder. Owns the fetch PC and issues one 32-bit instruction read per request over a valid/ready memory port. Buffers returned instructions in a small in-order FIFO, tagged with their PC, and presents them to the decoder with a stall input. Handles branch/jump redirects from execute by flushing the FIFO and discarding in-flight responses.

Parameters:
WIDTH__ADDR, 64, CPU address width (matches CpuAddr)
WIDTH__INSTR, 32, instruction width
DEPTH__BUF, 2, instruction buffer entries; also the maximum number of outstanding requests; power of two, at least 2
RESET_PC, 64'h0, PC loaded on reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
out_req_valid  out  1  memory read request valid
out_req_addr  out  WIDTH__ADDR  request address (the current PC)
in_req_ready  in  1  memory accepts the request this cycle
in_resp_valid  in  1  read data valid; responses return in request order
in_resp_instr  in  WIDTH__INSTR  returned instruction word
in_redirect_valid  in  1  redirect the PC (taken btru/bfal, jmp)
in_redirect_pc  in  WIDTH__ADDR  redirect target
in_decoder_stall  in  1  decoder cannot accept this cycle
out_instr_valid  out  1  buffer head is valid
out_instr  out  WIDTH__INSTR  head instruction; raw bits, fed to decoder casts (Iog0Instr..Iog3Instr)
out_instr_pc  out  WIDTH__ADDR  PC of the head instruction

Behaviour:
- Reset (async, rst=1): pc=RESET_PC; buffer count=0; outstanding=0; drop=0; out_req_valid=0; out_instr_valid=0; out_instr and out_instr_pc=0.
- Request issue: out_req_valid = !rst && !in_redirect_valid && (count + outstanding < DEPTH__BUF). out_req_addr = pc. A request is accepted when out_req_valid && in_req_ready. On acceptance, pc <= pc + 4 (wraps modulo 2^64), outstanding increments, and pc is pushed onto the pending-PC queue.
- Response: when in_resp_valid is high with drop>0, drop decrements and the data is discarded. With drop=0 and outstanding>0, the response is pushed to the buffer with the oldest pending PC, and outstanding decrements. A response with outstanding=0 and drop=0 is ignored.
- Output: out_instr_valid = count>0. A pop occurs when out_instr_valid && !in_decoder_stall. Response-to-output latency is 1 cycle: a response in cycle M is visible in cycle M+1. There is no bypass.
- Simultaneous events: a push and a pop in the same cycle leave count unchanged. The buffer never overflows, because issue is limited by count+outstanding.
- Redirect has priority over all other events in its cycle:
  - pc <= in_redirect_pc; buffer is flushed (count=0); no pop is counted; no request is issued (out_req_valid forced 0).
  - drop <= drop + outstanding, minus 1 if a response arrives that cycle. That response is discarded.
  - outstanding <= 0; pending-PC queue is cleared.
  - Fetch from the new PC starts the next cycle.
- Back-to-back redirects: the latest one wins, and drop accumulates correctly.
- Misaligned redirect target (low 2 bits non-zero): used as-is. The alignment check belongs to the execute stage.
- Counters are sized to hold the values 0..DEPTH__BUF. The pointers wrap modulo DEPTH__BUF.
- Reset mid-operation: all state clears immediately, and late responses are ignored under the rule above.

Decomposition:
- Package PkgSnow64InstrFetch:
  - typedefs FetchAddr and FetchInstr
  - the struct FetchBufEntry {instr, pc}
  - localparam WIDTH__FETCH_INCR = 4
  - reuse WIDTH__INSTR and WIDTH__ADDR from the decoder package's defines
- One sub-module: snow64_fetch_fifo. It is a synchronous FIFO of FetchBufEntry with push, pop, flush, count, and an async reset. It is instantiated twice: once for the instruction buffer and once, with only the pc field used, for the pending-PC queue.

Test Plan:
- Reset then free-run:
  - stimulus: rst high for 3 cycles, then in_req_ready=1, responses 1 cycle after each request, stall=0
  - required: req addrs 0, 4, 8, 12...; out_instr_pc follows 0, 4, 8 with each instruction 2 cycles after its request; outstanding never exceeds 2.
- Decoder stall:
  - stimulus: stall=1 from cycle 5
  - required: buffer fills to 2, out_req_valid drops to 0, out_instr holds the same word and PC; releasing the stall pops in order with no loss or duplication.
- Redirect with 2 outstanding:
  - stimulus: memory latency 3, redirect to 0x1000 while requests for 0x8 and 0xC are in flight
  - required: both responses discarded; the next out_instr_pc is 0x1000.
- Redirect coincident with a response and a pop:
  - stimulus: redirect, a response, and stall=0 all in the same cycle
  - required: the response is dropped, count=0 the next cycle, and no request issues in the redirect cycle.
- PC wrap:
  - stimulus: redirect to 64'hFFFF_FFFF_FFFF_FFFC
  - required: next request addresses are ...FFFC then 0x0.
- Async reset mid-flight:
  - stimulus: assert rst between clock edges with 2 outstanding requests and a full buffer
  - required: out_instr_valid and out_req_valid go to 0 immediately; stale responses after reset produce no output.
